// File: rtl/id_stage_pipe_pkg.sv
// id_pkg: shared constants for the decode stage.
//   - opcode encodings recognised by the decoder
//   - bit positions inside the 8-bit control word carried to EX
//   - peripheral-store FSM state encoding
//   - default peripheral window base
//   - decode_ctrl(): opcode -> control word
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Control word layout: {RegDst, ALUOp[1:0], ALUSrc, Branch, MemWrite, RegWrite, MemtoReg}
  localparam int CTRL_W        = 8;
  localparam int CTRL_REGDST   = 7;
  localparam int CTRL_ALUOP_HI = 6;
  localparam int CTRL_ALUOP_LO = 5;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_BRANCH   = 3;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_MEMTOREG = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } peri_state_e;

  localparam int DEFAULT_PERI_BASE = 256;

  function automatic logic [CTRL_W-1:0] decode_ctrl(input logic [5:0] opcode);
    logic [CTRL_W-1:0] c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        c[CTRL_REGDST]                  = 1'b1;
        c[CTRL_REGWRITE]                = 1'b1;
        c[CTRL_ALUOP_HI:CTRL_ALUOP_LO]  = 2'b10;
      end
      OP_ADDI: begin
        c[CTRL_ALUSRC]   = 1'b1;
        c[CTRL_REGWRITE] = 1'b1;
      end
      OP_LW: begin
        c[CTRL_ALUSRC]   = 1'b1;
        c[CTRL_REGWRITE] = 1'b1;
        c[CTRL_MEMTOREG] = 1'b1;
      end
      OP_SW: begin
        c[CTRL_ALUSRC]   = 1'b1;
        c[CTRL_MEMWRITE] = 1'b1;
      end
      OP_BEQ: begin
        c[CTRL_BRANCH]                  = 1'b1;
        c[CTRL_ALUOP_HI:CTRL_ALUOP_LO]  = 2'b01;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// id_stage_pipe_if: every handshake/bus signal of the decode stage.
//   fetch side : in_valid, in_ready, instn
//   write-back : wb_we, wb_addr, wb_data
//   EX hazard  : ex_load_pending, ex_load_rt
//   ID/EX slot : flush, ex_ready, out_valid, out_* operand/field/control outputs
//   peripheral : peri_req, peri_ack, peri_addr, peri_data
// modport slave  = the decode stage itself
// modport master = the surrounding pipeline (fetch, EX, WB, peripheral)
interface id_stage_pipe_if #(
  parameter int DATA_W  = 32,
  parameter int NREG    = 32,
  parameter int PERI_AW = 16
);
  localparam int AW = $clog2(NREG);

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instn;

  logic              wb_we;
  logic [AW-1:0]     wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic              ex_load_pending;
  logic [AW-1:0]     ex_load_rt;

  logic              flush;
  logic              ex_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_rs_data;
  logic [DATA_W-1:0] out_rt_data;
  logic [DATA_W-1:0] out_imm;
  logic [AW-1:0]     out_rs;
  logic [AW-1:0]     out_rt;
  logic [AW-1:0]     out_rd;
  logic [4:0]        out_shamt;
  logic [5:0]        out_funct;
  logic [5:0]        out_opcode;
  logic [7:0]        out_ctrl;

  logic              peri_req;
  logic              peri_ack;
  logic [PERI_AW-1:0] peri_addr;
  logic [15:0]       peri_data;

  modport slave (
    input  in_valid, instn,
    input  wb_we, wb_addr, wb_data,
    input  ex_load_pending, ex_load_rt,
    input  flush, ex_ready,
    input  peri_ack,
    output in_ready,
    output out_valid, out_rs_data, out_rt_data, out_imm,
    output out_rs, out_rt, out_rd, out_shamt, out_funct, out_opcode, out_ctrl,
    output peri_req, peri_addr, peri_data
  );

  modport master (
    output in_valid, instn,
    output wb_we, wb_addr, wb_data,
    output ex_load_pending, ex_load_rt,
    output flush, ex_ready,
    output peri_ack,
    input  in_ready,
    input  out_valid, out_rs_data, out_rt_data, out_imm,
    input  out_rs, out_rt, out_rd, out_shamt, out_funct, out_opcode, out_ctrl,
    input  peri_req, peri_addr, peri_data
  );

endinterface

// File: rtl/id_stage_pipe_regfile_bypass.sv
// regfile_bypass: NREG x DATA_W register file, two combinational read ports,
// one write port. Register 0 is hard-wired to zero. A write landing on the
// same register that is being read this cycle is forwarded to the read port.
// Ports:
//   clk, rst            clock, asynchronous active-high reset (clears all regs)
//   we, waddr, wdata    write port
//   raddr_a / rdata_a   read port A
//   raddr_b / rdata_b   read port B
module regfile_bypass #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  // r0 check comes last so it wins over the bypass of a write to r0.
  always_comb begin
    rdata_a = regs[raddr_a];
    if (we && waddr == raddr_a) rdata_a = wdata;
    if (raddr_a == '0) rdata_a = '0;
  end

  always_comb begin
    rdata_b = regs[raddr_b];
    if (we && waddr == raddr_b) rdata_b = wdata;
    if (raddr_b == '0) rdata_b = '0;
  end

endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode stage between fetch and execute.
//   - reads rs/rt from the bypassed register file
//   - decodes fields and the 8-bit control word
//   - stalls on load-use hazards against the LW currently in EX
//   - drives a registered ID/EX slot with a valid/ready handshake
//   - diverts stores at or above PERI_BASE to a req/ack peripheral port
// Ports: clk, rst (async active-high) and bus (id_stage_pipe_if.slave).
//
// Peripheral-store FSM:
//   state   | meaning
//   IDLE    | normal decode; a peripheral store launches a request
//   REQ     | peri_req held with stable address/data, waiting for peri_ack
//   HOLD    | ack received but the slot is busy; wait for slot_free to consume
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NREG      = 32,
  parameter int PERI_BASE = DEFAULT_PERI_BASE,
  parameter int PERI_AW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  id_stage_pipe_if.slave bus
);

  localparam int AW = $clog2(NREG);
  localparam logic [16:0] PERI_BASE_L = 17'(PERI_BASE);

  logic [5:0]        opcode;
  logic [AW-1:0]     rs;
  logic [AW-1:0]     rt;
  logic [AW-1:0]     rd;
  logic [4:0]        shamt;
  logic [5:0]        funct;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [CTRL_W-1:0] ctrl_dec;
  logic [CTRL_W-1:0] load_ctrl;

  logic uses_rt;
  logic haz;
  logic peri_store;
  logic slot_free;
  logic normal_ready;
  logic consume;
  logic load_slot;
  logic killed;

  peri_state_e state;

  assign opcode  = bus.instn[31:26];
  assign rs      = bus.instn[21 +: AW];
  assign rt      = bus.instn[16 +: AW];
  assign rd      = bus.instn[11 +: AW];
  assign shamt   = bus.instn[10:6];
  assign funct   = bus.instn[5:0];
  assign imm_ext = {{(DATA_W-16){bus.instn[15]}}, bus.instn[15:0]};
  assign ctrl_dec = decode_ctrl(opcode);

  regfile_bypass #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (bus.wb_we),
    .waddr   (bus.wb_addr),
    .wdata   (bus.wb_data),
    .raddr_a (rs),
    .rdata_a (rs_data),
    .raddr_b (rt),
    .rdata_b (rt_data)
  );

  // rt is only a source operand for R-type, SW (store data) and BEQ.
  assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);

  assign haz = bus.ex_load_pending && (bus.ex_load_rt != '0) &&
               ((bus.ex_load_rt == rs) || ((bus.ex_load_rt == rt) && uses_rt));

  assign peri_store = (opcode == OP_SW) && ({1'b0, bus.instn[15:0]} >= PERI_BASE_L);

  assign slot_free    = !bus.out_valid || bus.ex_ready;
  assign normal_ready = slot_free && !haz && (state == ST_IDLE) && !peri_store;

  // The held peripheral store is consumed once its ack is in and the slot can take it.
  assign consume = ((state == ST_REQ) && bus.peri_ack && slot_free) ||
                   ((state == ST_HOLD) && slot_free);

  assign bus.in_ready = !rst && (normal_ready || consume);

  assign load_slot = (bus.in_valid && normal_ready) || (consume && !killed);

  // A store that went out over the peripheral port must not also hit data memory.
  always_comb begin
    load_ctrl = ctrl_dec;
    if (state != ST_IDLE) load_ctrl[CTRL_MEMWRITE] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid   <= 1'b0;
      bus.out_rs_data <= '0;
      bus.out_rt_data <= '0;
      bus.out_imm     <= '0;
      bus.out_rs      <= '0;
      bus.out_rt      <= '0;
      bus.out_rd      <= '0;
      bus.out_shamt   <= '0;
      bus.out_funct   <= '0;
      bus.out_opcode  <= '0;
      bus.out_ctrl    <= '0;
      bus.peri_req    <= 1'b0;
      bus.peri_addr   <= '0;
      bus.peri_data   <= '0;
      killed          <= 1'b0;
      state           <= ST_IDLE;
    end else begin
      if (bus.flush) begin
        bus.out_valid <= 1'b0;
      end else if (load_slot) begin
        bus.out_valid   <= 1'b1;
        bus.out_rs_data <= rs_data;
        bus.out_rt_data <= rt_data;
        bus.out_imm     <= imm_ext;
        bus.out_rs      <= rs;
        bus.out_rt      <= rt;
        bus.out_rd      <= rd;
        bus.out_shamt   <= shamt;
        bus.out_funct   <= funct;
        bus.out_opcode  <= opcode;
        bus.out_ctrl    <= load_ctrl;
      end else if (slot_free) begin
        bus.out_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (bus.in_valid && peri_store && !haz) begin
            state         <= ST_REQ;
            bus.peri_req  <= 1'b1;
            bus.peri_addr <= bus.instn[PERI_AW-1:0];
            bus.peri_data <= rt_data[15:0];
          end
        end
        ST_REQ: begin
          if (bus.flush) killed <= 1'b1;
          if (bus.peri_ack) begin
            bus.peri_req <= 1'b0;
            if (slot_free) begin
              state  <= ST_IDLE;
              killed <= 1'b0;
            end else begin
              state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (bus.flush) killed <= 1'b1;
          if (slot_free) begin
            state  <= ST_IDLE;
            killed <= 1'b0;
          end
        end
        default: begin
          state        <= ST_IDLE;
          bus.peri_req <= 1'b0;
          killed       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
module tb_id_stage_pipe;

  localparam int DATA_W  = 32;
  localparam int NREG    = 32;
  localparam int PERI_AW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_stage_pipe_if #(.DATA_W(DATA_W), .NREG(NREG), .PERI_AW(PERI_AW)) bus ();

  id_stage_pipe #(
    .DATA_W(DATA_W), .NREG(NREG), .PERI_BASE(256), .PERI_AW(PERI_AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [5:0]  opcode;
    logic [7:0]  ctrl;
  } slot_t;

  slot_t       sb[$];
  slot_t       last;
  logic [31:0] mregs [32];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected control words, written out as literal bit patterns.
  function automatic logic [7:0] ctrl_exp(input logic [5:0] op);
    case (op)
      6'h00:   return 8'b1_10_0_0_0_1_0;
      6'h08:   return 8'b0_00_1_0_0_1_0;
      6'h23:   return 8'b0_00_1_0_0_1_1;
      6'h2B:   return 8'b0_00_1_0_1_0_0;
      6'h04:   return 8'b0_01_0_1_0_0_0;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] rd_model(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (bus.wb_we && bus.wb_addr == a) return bus.wb_data;
    return mregs[a];
  endfunction

  task automatic push_exp(input logic [31:0] ins, input bit nomw);
    slot_t e;
    e.opcode  = ins[31:26];
    e.rs      = ins[25:21];
    e.rt      = ins[20:16];
    e.rd      = ins[15:11];
    e.shamt   = ins[10:6];
    e.funct   = ins[5:0];
    e.imm     = {{16{ins[15]}}, ins[15:0]};
    e.rs_data = rd_model(e.rs);
    e.rt_data = rd_model(e.rt);
    e.ctrl    = ctrl_exp(e.opcode);
    if (nomw) e.ctrl[2] = 1'b0;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    if (bus.wb_we && bus.wb_addr != 5'd0) mregs[bus.wb_addr] = bus.wb_data;
    #1;
  endtask

  task automatic cmp_slot(input string tag, input slot_t e);
    chk({tag, ".rs_data"}, bus.out_rs_data, e.rs_data);
    chk({tag, ".rt_data"}, bus.out_rt_data, e.rt_data);
    chk({tag, ".imm"},     bus.out_imm,     e.imm);
    chk({tag, ".rs"},      32'(bus.out_rs),     32'(e.rs));
    chk({tag, ".rt"},      32'(bus.out_rt),     32'(e.rt));
    chk({tag, ".rd"},      32'(bus.out_rd),     32'(e.rd));
    chk({tag, ".shamt"},   32'(bus.out_shamt),  32'(e.shamt));
    chk({tag, ".funct"},   32'(bus.out_funct),  32'(e.funct));
    chk({tag, ".opcode"},  32'(bus.out_opcode), 32'(e.opcode));
    chk({tag, ".ctrl"},    32'(bus.out_ctrl),   32'(e.ctrl));
  endtask

  task automatic check_slot(input string tag);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s.scoreboard: observed empty queue expected an entry", tag);
    end else begin
      last = sb.pop_front();
      cmp_slot(tag, last);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins);
    bus.in_valid = v;
    bus.instn    = ins;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.instn = 32'd0;
    bus.wb_we = 1'b0;
    bus.wb_addr = '0;
    bus.wb_data = '0;
    bus.ex_load_pending = 1'b0;
    bus.ex_load_rt = '0;
    bus.flush = 1'b0;
    bus.ex_ready = 1'b1;
    bus.peri_ack = 1'b0;
    #2;
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.peri_req",  32'(bus.peri_req),  32'd0);
    chk("rst.in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst.out_ctrl",  32'(bus.out_ctrl),  32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;

    // ADDI r1,r0,5 then write r1=5 two cycles later
    drive(1, 32'h20010005);
    #1 chk("addi.in_ready", 32'(bus.in_ready), 32'd1);
    push_exp(bus.instn, 0);
    tick();
    check_slot("addi");
    drive(0, 32'd0);
    tick();
    chk("bubble.out_valid", 32'(bus.out_valid), 32'd0);
    bus.wb_we = 1'b1; bus.wb_addr = 5'd1; bus.wb_data = 32'd5;
    tick();
    bus.wb_we = 1'b0;

    // add r2,r1,r1
    drive(1, 32'h00211020);
    push_exp(bus.instn, 0);
    tick();
    check_slot("add_r1r1");

    // Same-cycle bypass onto r3, then write to r0 must still read 0
    bus.wb_we = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'hDEAD;
    drive(1, 32'h00603020);
    push_exp(bus.instn, 0);
    tick();
    check_slot("bypass_r3");
    bus.wb_addr = 5'd0; bus.wb_data = 32'd7;
    drive(1, 32'h00003820);
    push_exp(bus.instn, 0);
    tick();
    check_slot("r0_write");
    bus.wb_we = 1'b0;

    // Load-use stall on rs
    bus.ex_load_pending = 1'b1; bus.ex_load_rt = 5'd4;
    drive(1, 32'h00802820);
    #1 chk("haz.in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("haz.out_valid", 32'(bus.out_valid), 32'd0);
    bus.ex_load_pending = 1'b0;
    #1 chk("haz_release.in_ready", 32'(bus.in_ready), 32'd1);
    push_exp(bus.instn, 0);
    tick();
    check_slot("haz_release");

    // No hazard: ADDI does not source rt; pending rt of r0 never stalls
    bus.ex_load_pending = 1'b1; bus.ex_load_rt = 5'd9;
    drive(1, 32'h20090001);
    #1 chk("addi_rt_nohaz.in_ready", 32'(bus.in_ready), 32'd1);
    bus.ex_load_rt = 5'd0;
    drive(1, 32'h00003820);
    #1 chk("rt0_nohaz.in_ready", 32'(bus.in_ready), 32'd1);
    bus.ex_load_pending = 1'b0;
    drive(0, 32'd0);
    tick();

    // Backpressure
    drive(1, 32'h200B0077);
    push_exp(bus.instn, 0);
    tick();
    check_slot("bp_a");
    bus.ex_ready = 1'b0;
    drive(1, 32'h200C0088);
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp.in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      chk("bp.out_valid", 32'(bus.out_valid), 32'd1);
      cmp_slot("bp_hold", last);
    end
    bus.ex_ready = 1'b1;
    #1 chk("bp_release.in_ready", 32'(bus.in_ready), 32'd1);
    push_exp(bus.instn, 0);
    tick();
    check_slot("bp_b");

    // r2 = 0x1234, then peripheral store to 0x0140
    drive(0, 32'd0);
    bus.wb_we = 1'b1; bus.wb_addr = 5'd2; bus.wb_data = 32'h1234;
    tick();
    bus.wb_we = 1'b0;
    drive(1, 32'hAC020140);
    #1 chk("peri.in_ready_idle", 32'(bus.in_ready), 32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("peri.req",  32'(bus.peri_req),  32'd1);
      chk("peri.addr", 32'(bus.peri_addr), 32'h0140);
      chk("peri.data", 32'(bus.peri_data), 32'h1234);
      chk("peri.in_ready_req", 32'(bus.in_ready), 32'd0);
      tick();
    end
    chk("peri.out_valid_wait", 32'(bus.out_valid), 32'd0);
    bus.peri_ack = 1'b1;
    #1 chk("peri_ack.in_ready", 32'(bus.in_ready), 32'd1);
    push_exp(bus.instn, 1);
    tick();
    bus.peri_ack = 1'b0;
    drive(0, 32'd0);
    check_slot("peri_slot");
    chk("peri_done.req", 32'(bus.peri_req), 32'd0);

    // Flush during REQ: handshake completes, slot stays empty
    drive(1, 32'hAC020200);
    tick();
    chk("fl.req",  32'(bus.peri_req),  32'd1);
    chk("fl.addr", 32'(bus.peri_addr), 32'h0200);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("fl.out_valid", 32'(bus.out_valid), 32'd0);
    chk("fl.req_held", 32'(bus.peri_req), 32'd1);
    bus.peri_ack = 1'b1;
    #1 chk("fl_ack.in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.peri_ack = 1'b0;
    drive(0, 32'd0);
    chk("fl_ack.out_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_ack.req", 32'(bus.peri_req), 32'd0);
    drive(1, 32'h20090001);
    #1 chk("fl_next.in_ready", 32'(bus.in_ready), 32'd1);
    push_exp(bus.instn, 0);
    tick();
    check_slot("fl_next");

    // Ack while the slot is busy -> HOLD, consumed once EX drains
    bus.ex_ready = 1'b0;
    drive(1, 32'hAC020300);
    tick();
    chk("hold.req", 32'(bus.peri_req), 32'd1);
    chk("hold.out_valid", 32'(bus.out_valid), 32'd1);
    bus.peri_ack = 1'b1;
    tick();
    bus.peri_ack = 1'b0;
    chk("hold.req_dropped", 32'(bus.peri_req), 32'd0);
    #1 chk("hold.in_ready", 32'(bus.in_ready), 32'd0);
    bus.ex_ready = 1'b1;
    #1 chk("hold_release.in_ready", 32'(bus.in_ready), 32'd1);
    push_exp(bus.instn, 1);
    tick();
    drive(0, 32'd0);
    check_slot("hold_slot");

    // Store just below the window takes the normal path
    drive(1, 32'hAC0200FF);
    #1 chk("sw_ff.in_ready", 32'(bus.in_ready), 32'd1);
    push_exp(bus.instn, 0);
    tick();
    check_slot("sw_ff");
    chk("sw_ff.req", 32'(bus.peri_req), 32'd0);

    // LW, BEQ (negative immediate), unknown opcode
    drive(1, 32'h8C280004);
    push_exp(bus.instn, 0);
    tick();
    check_slot("lw");
    drive(1, 32'h1022FFFF);
    push_exp(bus.instn, 0);
    tick();
    check_slot("beq");
    drive(1, 32'hFC000000);
    push_exp(bus.instn, 0);
    tick();
    check_slot("nop");

    // Flush beats a same-cycle accept
    drive(1, 32'h20010005);
    bus.flush = 1'b1;
    #1 chk("flacc.in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.flush = 1'b0;
    drive(0, 32'd0);
    chk("flacc.out_valid", 32'(bus.out_valid), 32'd0);

    // Async reset in the middle of a peripheral request
    drive(1, 32'hAC020140);
    tick();
    chk("rstmid.req_before", 32'(bus.peri_req), 32'd1);
    drive(0, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rstmid.req", 32'(bus.peri_req), 32'd0);
    chk("rstmid.peri_addr", 32'(bus.peri_addr), 32'd0);
    chk("rstmid.in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    rst = 1'b0;
    tick();
    drive(1, 32'h00223020);
    #1 chk("post_rst.in_ready", 32'(bus.in_ready), 32'd1);
    push_exp(bus.instn, 0);
    tick();
    drive(0, 32'd0);
    check_slot("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
